// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus slice: opcode encodings,
// the reserved "no producer" tag and default bus dimensions.
package cdb_pkg;

    // Floating-point opcodes carried by the stations that feed the bus
    typedef enum logic [3:0] {
        ADD_D = 4'b0000,
        SUB_D = 4'b0001,
        L_D   = 4'b0010,
        S_D   = 4'b0011
    } fp_op_e;

    // Tag value meaning "register value is ready, nobody will produce it"
    localparam int TAG_NONE = 0;

    // Default dimensions of the bus and register file
    localparam int DEF_NCH  = 4;
    localparam int DEF_DW   = 16;
    localparam int DEF_NREG = 8;
    localparam int DEF_TW   = 3;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// One-hot grant arbiter for the common data bus producers.
// Build option CDB_RR_EN: round-robin grant with a rotating pointer;
// without it the lowest requesting index always wins and no state is kept.
module cdb_rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] gnt_o
);

`ifdef CDB_RR_EN
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Search requests starting at the pointer; the winner's successor becomes the next start
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        gnt_o = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % NCH);
            end
        end
    end

    // Pointer register; it only moves when some request was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    // Fixed priority: lowest requesting index is granted
    always_comb begin
        logic found;
        found = 1'b0;
        gnt_o = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cdb_broadcast.sv
// Common data bus for the Tomasulo core: arbitrates producer channels,
// broadcasts the winner on a registered bus and owns the FP register file
// with its producer-tag (Qi) table. Build option CDB_RR_EN selects
// round-robin arbitration inside cdb_rr_arbiter.
module cdb_broadcast
    import cdb_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    parameter int TW   = DEF_TW,
    parameter int RW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    fu_valid_i,
    output logic [NCH-1:0]    fu_ready_o,
    input  logic [NCH*TW-1:0] fu_tag_i,
    input  logic [NCH*DW-1:0] fu_data_i,
    input  logic              iss_valid_i,
    input  logic [RW-1:0]     iss_reg_i,
    input  logic [TW-1:0]     iss_tag_i,
    input  logic [RW-1:0]     rd_addr_i,
    output logic [DW-1:0]     rd_data_o,
    output logic [TW-1:0]     rd_tag_o,
    output logic              cdb_valid_o,
    output logic [TW-1:0]     cdb_tag_o,
    output logic [DW-1:0]     cdb_data_o
);

    logic [NCH-1:0] gnt;
    logic [TW-1:0]  win_tag;
    logic [DW-1:0]  win_data;
    logic           accept;

    logic           cdb_valid_q, cdb_valid_d;
    logic [TW-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DW-1:0]  cdb_data_q, cdb_data_d;

    logic [DW-1:0]  data_q   [NREG];
    logic [DW-1:0]  data_d   [NREG];
    logic [TW-1:0]  status_q [NREG];
    logic [TW-1:0]  status_d [NREG];

    logic           bypass;

    cdb_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (fu_valid_i & {NCH{rst_n}}),
        .gnt_o (gnt)
    );

    assign fu_ready_o = gnt & {NCH{rst_n}};
    assign accept     = |fu_ready_o;

    // Select the granted channel's tag and data from the one-hot grant
    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (fu_ready_o[i]) begin
                win_tag  = win_tag  | fu_tag_i[i*TW +: TW];
                win_data = win_data | fu_data_i[i*DW +: DW];
            end
        end
    end

    // Next bus contents: a beat tagged "no producer" is swallowed, idle cycles hold tag/data
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (accept && (win_tag != TW'(TAG_NONE))) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = win_tag;
            cdb_data_d  = win_data;
        end
    end

    // Registered broadcast bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // Writeback to every waiting register, then issue renaming overrides the status
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            data_d[r]   = data_q[r];
            status_d[r] = status_q[r];
            if (cdb_valid_q && (status_q[r] == cdb_tag_q)) begin
                data_d[r]   = cdb_data_q;
                status_d[r] = TW'(TAG_NONE);
            end
            if (iss_valid_i && (iss_reg_i == RW'(r))) begin
                status_d[r] = iss_tag_i;
            end
        end
    end

    // Register file and status table state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r]   <= '0;
                status_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r]   <= data_d[r];
                status_q[r] <= status_d[r];
            end
        end
    end

    // Operand read sees the value being broadcast this cycle before it lands in the file
    always_comb begin
        bypass    = cdb_valid_q && (status_q[rd_addr_i] == cdb_tag_q);
        rd_data_o = data_q[rd_addr_i];
        rd_tag_o  = status_q[rd_addr_i];
        if (bypass) begin
            rd_data_o = cdb_data_q;
            rd_tag_o  = TW'(TAG_NONE);
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed bench for cdb_broadcast with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_cdb_broadcast;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TW  = 3;
    localparam int RW  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    fu_valid = '0;
    logic [NCH-1:0]    fu_ready;
    logic [NCH*TW-1:0] fu_tag = '0;
    logic [NCH*DW-1:0] fu_data = '0;
    logic              iss_valid = 1'b0;
    logic [RW-1:0]     iss_reg = '0;
    logic [TW-1:0]     iss_tag = '0;
    logic [RW-1:0]     rd_addr = '0;
    logic [DW-1:0]     rd_data;
    logic [TW-1:0]     rd_tag;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;

    int checkCount = 0;
    int errorCount = 0;

    cdb_broadcast #(.NCH(NCH), .DW(DW), .NREG(8), .TW(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fu_valid_i  (fu_valid),
        .fu_ready_o  (fu_ready),
        .fu_tag_i    (fu_tag),
        .fu_data_i   (fu_data),
        .iss_valid_i (iss_valid),
        .iss_reg_i   (iss_reg),
        .iss_tag_i   (iss_tag),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_tag_o    (rd_tag),
        .cdb_valid_o (cdb_valid),
        .cdb_tag_o   (cdb_tag),
        .cdb_data_o  (cdb_data)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Load one producer channel's tag and data
    task automatic setChannel(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        fu_tag[ch*TW +: TW]  = tag;
        fu_data[ch*DW +: DW] = data;
    endtask

    // Drive producer valids and the issue port for the coming edge
    task automatic applyStimulus(input logic [NCH-1:0] valid, input logic iv,
                                 input logic [RW-1:0] ireg, input logic [TW-1:0] itag);
        fu_valid  = valid;
        iss_valid = iv;
        iss_reg   = ireg;
        iss_tag   = itag;
    endtask

    // Point the read port and check what it returns
    task automatic checkRead(input string name, input logic [RW-1:0] addr,
                             input logic [DW-1:0] expData, input logic [TW-1:0] expTag);
        rd_addr = addr;
        #1;
        checkOutput({name, "_data"}, 32'(rd_data), 32'(expData));
        checkOutput({name, "_tag"}, 32'(rd_tag), 32'(expTag));
    endtask

    initial begin
        int expCh;

        // Reset with every channel requesting
        for (int i = 0; i < NCH; i++) setChannel(i, TW'(i + 1), DW'(16'h0100 + i));
        applyStimulus(4'b1111, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ready", 32'(fu_ready), 32'h0);
        checkOutput("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        for (int a = 0; a < 8; a++) checkRead("rst_rd", RW'(a), '0, '0);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: all four channels requesting continuously
        @(negedge clk);
        applyStimulus(4'b1111, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            #1;
`ifdef CDB_RR_EN
            expCh = k % NCH;
`else
            expCh = 0;
`endif
            checkOutput("cont_grant", 32'(fu_ready), 32'(1) << expCh);
            @(negedge clk);
            checkOutput("cont_valid", 32'(cdb_valid), 32'h1);
            checkOutput("cont_tag", 32'(cdb_tag), 32'(expCh + 1));
        end
        applyStimulus(4'b0000, 1'b0, '0, '0);

        // Rename reg 3 to tag 5, then channel 1 produces tag 5
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1, 3'd3, 3'd5);
        @(negedge clk);
        applyStimulus(4'b0010, 1'b0, '0, '0);
        setChannel(1, 3'd5, 16'h1234);
        checkRead("ren_pending", 3'd3, 16'h0000, 3'd5);
        checkOutput("ren_grant", 32'(fu_ready), 32'h2);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        #1;
        checkOutput("ren_cdb_valid", 32'(cdb_valid), 32'h1);
        checkOutput("ren_cdb_tag", 32'(cdb_tag), 32'h5);
        checkOutput("ren_cdb_data", 32'(cdb_data), 32'h1234);
        @(negedge clk);
        checkOutput("ren_idle", 32'(cdb_valid), 32'h0);
        checkOutput("ren_tag_hold", 32'(cdb_tag), 32'h5);
        checkRead("ren_wb", 3'd3, 16'h1234, 3'd0);

        // Issue and writeback colliding on reg 2
        applyStimulus(4'b0000, 1'b1, 3'd2, 3'd4);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, '0, '0);
        setChannel(0, 3'd4, 16'h00AA);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1, 3'd2, 3'd6);
        #1;
        checkOutput("col_cdb_valid", 32'(cdb_valid), 32'h1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        checkRead("col_reg2", 3'd2, 16'h00AA, 3'd6);

        // Two registers waiting on tag 7, bypass during broadcast
        applyStimulus(4'b0000, 1'b1, 3'd1, 3'd7);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1, 3'd5, 3'd7);
        @(negedge clk);
        applyStimulus(4'b0100, 1'b0, '0, '0);
        setChannel(2, 3'd7, 16'hBEEF);
        checkRead("mm_wait1", 3'd1, 16'h0000, 3'd7);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        checkRead("mm_byp5", 3'd5, 16'hBEEF, 3'd0);
        checkRead("mm_byp1", 3'd1, 16'hBEEF, 3'd0);
        @(negedge clk);
        checkRead("mm_reg5", 3'd5, 16'hBEEF, 3'd0);
        checkRead("mm_reg1", 3'd1, 16'hBEEF, 3'd0);

        // Issuing tag 0 marks ready without touching data
        applyStimulus(4'b0000, 1'b1, 3'd1, 3'd3);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1, 3'd1, 3'd0);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        checkRead("iss0_reg1", 3'd1, 16'hBEEF, 3'd0);

        // A beat tagged 0 is granted but never broadcast
        applyStimulus(4'b1000, 1'b0, '0, '0);
        setChannel(3, 3'd0, 16'h5555);
        #1;
        checkOutput("tag0_grant", 32'(fu_ready), 32'h8);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        #1;
        checkOutput("tag0_valid", 32'(cdb_valid), 32'h0);
        checkOutput("tag0_data_hold", 32'(cdb_data), 32'hBEEF);

        // Reset asserted while a broadcast is on the bus
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1, 3'd6, 3'd3);
        @(negedge clk);
        applyStimulus(4'b0010, 1'b0, '0, '0);
        setChannel(1, 3'd3, 16'h7777);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, '0, '0);
        #1;
        checkOutput("mid_cdb_valid", 32'(cdb_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(cdb_valid), 32'h0);
        checkOutput("mid_rst_tag", 32'(cdb_tag), 32'h0);
        checkOutput("mid_rst_data", 32'(cdb_data), 32'h0);
        checkRead("mid_rst_reg6", 3'd6, 16'h0000, 3'd0);
        checkRead("mid_rst_reg3", 3'd3, 16'h0000, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkRead("post_rst_reg6", 3'd6, 16'h0000, 3'd0);
        checkOutput("post_rst_valid", 32'(cdb_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cdb_broadcast.md
# cdb_broadcast

Parametrised common data bus for the Tomasulo core. It accepts results from NCH functional-unit/reservation-station channels and arbitrates one winner per cycle. It broadcasts the winner's tag and data on a registered bus, and owns the FP register file plus its register-status (Qi) table, so tag-matched writeback and issue-time renaming happen in one place.

## Interface
- NCH, 4: number of producer channels (2..8)
- DW, 16: data width
- NREG, 8: architectural FP registers
- TW, 3: tag width; tag 0 reserved = "value ready / no producer"
- clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- fu_valid  in  NCH  channel i holds a result
- fu_ready  out  NCH  one-hot grant; transfer on fu_valid[i] & fu_ready[i]
- fu_tag  in  NCH*TW  producing-station tag, channel i at [i*TW +: TW]
- fu_data  in  NCH*DW  result, channel i at [i*DW +: DW]
- iss_valid  in  1  issue renames a destination register this cycle
- iss_reg  in  clog2(NREG)  destination register
- iss_tag  in  TW  new producer tag for iss_reg
- rd_addr  in  clog2(NREG)  read port address (operand fetch at issue)
- rd_data  out  DW  register value, combinational
- rd_tag  out  TW  pending producer tag, 0 if value valid, combinational
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TW  broadcast tag
- cdb_data  out  DW  broadcast data

## Operation
- Arbitration is combinational over fu_valid. fu_ready is one-hot or zero, and only a valid channel is granted.
- Winner is captured into cdb_valid/cdb_tag/cdb_data at the edge. With no winner, cdb_valid=0 and tag/data hold.
- Writeback uses the registered bus. While cdb_valid is high, every register r with status[r]==cdb_tag gets data[r]<=cdb_data and status[r]<=0. Multiple registers may match.
- Issue: status[iss_reg]<=iss_tag. iss_tag==0 marks the register ready and leaves data unchanged.
- Issue and writeback hit the same register in the same cycle: data is written, status takes iss_tag (issue wins).
- Read bypass: if cdb_valid and status[rd_addr]==cdb_tag, then rd_data=cdb_data and rd_tag=0. Otherwise the stored values are returned.
- fu_valid with fu_tag==0 is a protocol error. It may be granted; the accepted beat is dropped with cdb_valid=0.
- Tag uniqueness among in-flight producers is the issuer's responsibility.

## Timing
- Reset values: fu_ready=0, cdb_valid=0, cdb_tag=0, cdb_data=0, all data[r]=0, all status[r]=0, arbiter pointer=0.
- Latency: accept at edge E → cdb_valid high after E → register file/status updated at E+1.
- Throughput: one broadcast per cycle, back-to-back without bubbles.
- A channel held off keeps fu_valid/fu_tag/fu_data stable until granted.
- Reset asserted mid-broadcast clears everything immediately. No partial writeback survives.

## Configuration
- CDB_RR_EN defined: round-robin grant. Pointer advances to winner+1 mod NCH after each accepted beat, and holds when idle.
- CDB_RR_EN undefined: fixed priority, lowest index wins. No pointer state.

## Structure
- Shared package cdb_pkg holds:
  - opcode constants: ADD_D=4'b0000, SUB_D=4'b0001, L_D=4'b0010, S_D=4'b0011;
  - TAG_NONE=0;
  - default DW/TW/NREG.
- One sub-module, cdb_rr_arbiter: request vector in, one-hot grant out, pointer state under CDB_RR_EN. Register file and status table stay in cdb_broadcast.

## Test plan
- Reset: fu_valid=4'b1111 held during Reset=0 → fu_ready=0, cdb_valid=0, rd_tag=0, rd_data=0 for all rd_addr.
- Rename/writeback: issue reg 3 tag 5. Channel 1 sends tag 5 data 16'h1234 → cdb_valid one cycle later, then rd_addr=3 gives data 16'h1234, tag 0.
- Contention with CDB_RR_EN: channels 0–3 valid continuously → grants 0,1,2,3,0 on consecutive cycles. Without the macro → channel 0 every cycle while valid.
- Issue/writeback collision: reg 2 status tag 4. Broadcast tag 4 data 16'h00AA in the same cycle as issue reg 2 tag 6 → data[2]=16'h00AA, rd_tag=6.
- Multi-match and bypass: regs 1 and 5 both tag 7. Broadcast tag 7 data 16'hBEEF → during the broadcast cycle rd_addr=5 reads 16'hBEEF, tag 0. Next cycle both registers hold 16'hBEEF.
- Reset mid-stream: assert Reset while cdb_valid=1 → outputs and all status clear asynchronously. The pending write is not applied after release.
